// File: rtl/stack_reverser.sv
// stack_reverser: client-side controller for a PushDownStack. Accepts a framed
// valid/ready byte stream, pushes each beat, and on end of frame pops the stack
// back out so each frame leaves in reverse order.
//
// Optional feature macro: STACK_REV_FLUSH_EN adds a `flush` input and a DISCARD
// state that empties the stack without emitting any beat.
//
// Ports:
//   Clk, Rst                   clock, async active-low reset (shared with stack)
//   in_data/in_valid/in_last   upstream beat, in_ready back-pressure
//   out_data/out_valid/out_last reversed beat (registered), out_ready accept
//   stk_en/stk_pushpop/stk_wdata  stack controls (pushpop 0 = push, 1 = pop)
//   stk_rdata/stk_empty/stk_full  stack status; rdata valid the cycle after a pop
//   overflow                   sticky: a frame was force-ended by a full stack
//   flush (macro only)         discard the frame in flight
module stack_reverser #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst,
`ifdef STACK_REV_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              stk_en,
  output logic              stk_pushpop,
  output logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] stk_rdata,
  input  logic              stk_empty,
  input  logic              stk_full,
  output logic              overflow
);

  typedef enum logic [2:0] {
    FILL,
    POP,
    CAPT,
    OUT
`ifdef STACK_REV_FLUSH_EN
    , DISCARD
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             flush_req;

`ifdef STACK_REV_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // A flush request in FILL wins over a push so the discarded frame cannot grow.
  assign in_ready = (state == FILL) && !stk_full && !flush_req;
  assign accept   = in_valid && in_ready;

  // Pushes are combinational on accept; pops are driven from POP (and DISCARD).
  // Never issue a pop to an empty stack, even if count and the stack disagree.
  always_comb begin
    stk_en = accept || ((state == POP) && !stk_empty);
`ifdef STACK_REV_FLUSH_EN
    if ((state == DISCARD) && (count != '0) && !stk_empty) stk_en = 1'b1;
`endif
  end
  assign stk_pushpop = (state != FILL);
  assign stk_wdata   = in_data;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= FILL;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (flush_req) begin
`ifdef STACK_REV_FLUSH_EN
            state <= DISCARD;
`endif
          end else if (accept) begin
            if (count != CNT_MAX) count <= count + 1'b1;
            if (in_last) state <= POP;
          end else if (stk_full && in_valid) begin
            // Stack is full with a beat waiting: close the frame here. The
            // waiting beat stays on the input and starts the next frame.
            overflow <= 1'b1;
            state    <= POP;
          end
        end
        POP: begin
          // The pop already hit the stack this cycle, so count follows it
          // even if a flush diverts the FSM.
          if (count != '0) count <= count - 1'b1;
          state <= CAPT;
`ifdef STACK_REV_FLUSH_EN
          if (flush_req) state <= DISCARD;
`endif
        end
        CAPT: begin
          if (flush_req) begin
`ifdef STACK_REV_FLUSH_EN
            state <= DISCARD;
`endif
          end else begin
            out_data  <= stk_rdata;
            out_valid <= 1'b1;
            // count was decremented in POP, so zero marks the first-in beat.
            out_last  <= (count == '0);
            state     <= OUT;
          end
        end
        OUT: begin
          if (flush_req) begin
            out_valid <= 1'b0;
`ifdef STACK_REV_FLUSH_EN
            state     <= DISCARD;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= (count != '0) ? POP : FILL;
          end
        end
`ifdef STACK_REV_FLUSH_EN
        DISCARD: begin
          out_valid <= 1'b0;
          if (count != '0) count <= count - 1'b1;
          else             state <= FILL;
        end
`endif
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_reverser.sv
module tb_stack_reverser;
  localparam int DW = 8;
  localparam int DEPTH = 128;

  logic          Clk, Rst;
  logic [DW-1:0] in_data, out_data, stk_wdata, stk_rdata;
  logic          in_valid, in_last, in_ready;
  logic          out_valid, out_last, out_ready;
  logic          stk_en, stk_pushpop, stk_empty, stk_full, overflow;
`ifdef STACK_REV_FLUSH_EN
  logic          flush;
`endif

  int checks = 0;
  int errors = 0;

  stack_reverser #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst),
`ifdef STACK_REV_FLUSH_EN
    .flush(flush),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .stk_en(stk_en), .stk_pushpop(stk_pushpop), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .stk_empty(stk_empty), .stk_full(stk_full),
    .overflow(overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural PushDownStack: registered data_o, empty/full from stack pointer.
  logic [DW-1:0] mem [DEPTH];
  int sp;
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sp        <= 0;
      stk_rdata <= '0;
    end else if (stk_en) begin
      if (!stk_pushpop && sp < DEPTH) begin
        mem[sp] <= stk_wdata;
        sp      <= sp + 1;
      end else if (stk_pushpop && sp > 0) begin
        stk_rdata <= mem[sp-1];
        sp        <= sp - 1;
      end
    end
  end
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == DEPTH);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    int n;
    @(negedge Clk);
    in_data = d; in_valid = 1'b1; in_last = l;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge Clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait for an output beat, optionally stall it, then accept and compare.
  task automatic recv(input logic [DW-1:0] d, input logic l, input int stall, input string nm);
    int n;
    @(negedge Clk);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!out_valid) chk({nm, "_timeout"}, 0, 1);
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge Clk);
        chk({nm, "_hold_data"}, out_data, d);
        chk({nm, "_hold_vld"}, out_valid, 1);
        chk({nm, "_hold_noen"}, stk_en, 0);
      end
    end
    out_ready = 1'b1;
    chk({nm, "_data"}, out_data, d);
    chk({nm, "_last"}, out_last, l);
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    int          len;
    logic [7:0]  din  [5];
    logic [7:0]  dexp [5];
    int          stall;
  } vec_t;

  vec_t tbl [3];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0].len = 3; tbl[0].stall = 0;
    tbl[0].din  = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
    tbl[0].dexp = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h00};
    tbl[1].len = 5; tbl[1].stall = 6;
    tbl[1].din  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    tbl[1].dexp = '{8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    tbl[2].len = 4; tbl[2].stall = 1;
    tbl[2].din  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    tbl[2].dexp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};

    Rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
`ifdef STACK_REV_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_stk_en", stk_en, 0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_in_ready", in_ready, 1);

    // Table frames: push, drain reversed, check stack empty and back in FILL.
    for (int t = 0; t < 3; t++) begin
      out_ready = 1'b0;
      for (int j = 0; j < tbl[t].len; j++) push(tbl[t].din[j], j == tbl[t].len - 1);
      for (int j = 0; j < tbl[t].len; j++)
        recv(tbl[t].dexp[j], j == tbl[t].len - 1, (j == 0) ? tbl[t].stall : 0,
             $sformatf("tbl%0d_b%0d", t, j));
      @(negedge Clk);
      chk($sformatf("tbl%0d_empty", t), stk_empty, 1);
      chk($sformatf("tbl%0d_fill", t), in_ready, 1);
    end

    // Single beat: out_valid rises on the second edge after the accept edge.
    out_ready = 1'b0;
    push(8'hAA, 1'b1);
    @(negedge Clk);
    @(negedge Clk);
    chk("single_lat_early", out_valid, 0);
    @(negedge Clk);
    chk("single_lat", out_valid, 1);
    recv(8'hAA, 1'b1, 0, "single");

    // Overflow: 128 beats with no last, then a held beat while full.
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge Clk);
      in_data = 8'(i); in_valid = 1'b1; in_last = 1'b0;
      if (i == 0 || i == DEPTH - 1) chk($sformatf("ovf_ready%0d", i), in_ready, 1);
      @(posedge Clk);
    end
    @(negedge Clk);
    in_data = 8'h80;
    chk("ovf_full_ready", in_ready, 0);
    chk("ovf_pre", overflow, 0);
    @(posedge Clk);
    @(negedge Clk);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_drain_ready", in_ready, 0);
    for (int i = DEPTH - 1; i >= 0; i--) recv(8'(i), i == 0, 0, $sformatf("ovf_b%0d", i));
    @(negedge Clk);
    chk("ovf_end_empty", stk_empty, 1);
    chk("ovf_held_ready", in_ready, 1);
    @(posedge Clk);
    #1 in_valid = 1'b0;
    @(negedge Clk);
    chk("ovf_held_taken", stk_empty, 0);
    push(8'h81, 1'b1);
    recv(8'h81, 1'b0, 0, "ovf_nf0");
    recv(8'h80, 1'b1, 0, "ovf_nf1");
    chk("ovf_still", overflow, 1);

    // Reset mid-drain.
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) push(8'h21 + 8'(j), j == 4);
    recv(8'h25, 1'b0, 0, "rst_b0");
    recv(8'h24, 1'b0, 0, "rst_b1");
    out_ready = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(negedge Clk);
        n++;
      end
      chk("rst_mid_valid", out_valid, 1);
    end
    Rst = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_count", dut.count, 0);
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_rel_ready", in_ready, 1);
    chk("rst_rel_empty", stk_empty, 1);
    chk("rst_rel_ovf", overflow, 0);
    push(8'h31, 1'b1);
    recv(8'h31, 1'b1, 0, "rst_new");

`ifdef STACK_REV_FLUSH_EN
    begin
      int pops = 0;
      int vld = 0;
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) push(8'h40 + 8'(j), 1'b0);
      @(negedge Clk);
      flush = 1'b1;
      chk("flush_ready", in_ready, 0);
      @(negedge Clk);
      flush = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (stk_en && stk_pushpop) pops++;
        if (out_valid) vld++;
        @(negedge Clk);
      end
      chk("flush_pops", pops, 5);
      chk("flush_no_valid", vld, 0);
      chk("flush_empty", stk_empty, 1);
      chk("flush_fill", in_ready, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
